seg7_scan_capture: RTL and testbench

- Reader for the multiplexed 7-segment display bus: samples the time-multiplexed anode and segment lines driven by the stopwatch display path and recovers the 4-bit digit value shown on each position.
- Per-digit stability filtering, inverse segment decode, blank/invalid-pattern detection and a frame-complete pulse.
- Used as an on-chip self-check and as the display monitor in system benches.

---
 rtl/seg7_scan_capture.sv | 139 +++++++++++++
 tb/tb_seg7_scan_capture.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_capture.sv
// Recovers per-position digit values from a multiplexed active-low 7-segment bus.
// Latency: one input-register cycle plus STABLE_CYCLES of stability; no backpressure (free-running monitor).
module seg7_scan_capture #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_DIGITS-1:0]   anode_n,
    input  logic [6:0]              segment,
    input  logic                    err_clr,
    output logic [4*NUM_DIGITS-1:0] digits_out,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    frame_done,
    output logic                    error_sticky
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [NUM_DIGITS-1:0] anode_r;
    logic [6:0]            seg_r;
    logic [CNT_W-1:0]      cnt;
    logic                  cap_done;
    logic [NUM_DIGITS-1:0] mask;

    logic [NUM_DIGITS-1:0] sel;
    logic                  active;
    logic [IDX_W-1:0]      pos;
    logic                  same;
    logic                  hold_ok;
    logic                  capture;
    logic [3:0]            dec_val;
    logic                  dec_digit;
    logic                  dec_blank;
    logic [NUM_DIGITS-1:0] mask_nxt;

    // Exactly one low anode bit means a single position is being driven.
    always_comb begin
        sel    = ~anode_r;
        active = (|sel) && ~|(sel & (sel - NUM_DIGITS'(1)));
        pos    = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel[i]) begin
                pos = IDX_W'(i);
            end
        end
    end

    always_comb begin
        dec_val   = 4'hF;
        dec_digit = 1'b1;
        dec_blank = 1'b0;
        case (seg_r)
            7'b0000001: dec_val = 4'd0;
            7'b1001111: dec_val = 4'd1;
            7'b0010010: dec_val = 4'd2;
            7'b0000110: dec_val = 4'd3;
            7'b1001100: dec_val = 4'd4;
            7'b0100100: dec_val = 4'd5;
            7'b0100000: dec_val = 4'd6;
            7'b0001111: dec_val = 4'd7;
            7'b0000000: dec_val = 4'd8;
            7'b0000100: dec_val = 4'd9;
            7'b1111111: begin
                dec_digit = 1'b0;
                dec_blank = 1'b1;
            end
            default: dec_digit = 1'b0;
        endcase
    end

    // The incoming pins are the next registered sample, so comparing them with
    // the current registered pair lets the capture land exactly STABLE_CYCLES
    // edges after the pattern is first registered.
    assign same     = ({anode_n, segment} == {anode_r, seg_r});
    assign hold_ok  = same && active;
    assign capture  = active && (cnt == CNT_MAX) && !cap_done;
    assign mask_nxt = mask | sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            anode_r      <= '1;
            seg_r        <= 7'b1111111;
            cnt          <= '0;
            cap_done     <= 1'b0;
            mask         <= '0;
            digits_out   <= '1;
            digit_valid  <= '0;
            frame_done   <= 1'b0;
            error_sticky <= 1'b0;
        end else begin
            anode_r    <= anode_n;
            seg_r      <= segment;
            frame_done <= 1'b0;

            if (hold_ok) begin
                if (cnt != CNT_MAX) begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end

            // A changing pair re-arms capture even on the capture edge itself.
            if (!hold_ok) begin
                cap_done <= 1'b0;
            end else if (capture) begin
                cap_done <= 1'b1;
            end

            if (capture) begin
                if (dec_digit) begin
                    digits_out[4*pos +: 4] <= dec_val;
                    digit_valid[pos]       <= 1'b1;
                end else if (dec_blank) begin
                    digits_out[4*pos +: 4] <= 4'hF;
                    digit_valid[pos]       <= 1'b0;
                end else begin
                    digit_valid[pos]       <= 1'b0;
                end
                if (&mask_nxt) begin
                    mask       <= '0;
                    frame_done <= 1'b1;
                end else begin
                    mask <= mask_nxt;
                end
            end

            if (capture && !dec_digit && !dec_blank) begin
                error_sticky <= 1'b1;
            end else if (err_clr) begin
                error_sticky <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Bench for seg7_scan_capture: directed scans plus random traffic against a run-length reference model.
module tb_seg7_scan_capture;

    localparam int N = 4;
    localparam int S = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  anode_n;
    logic [6:0]    segment;
    logic          err_clr;
    logic [4*N-1:0] digits_out;
    logic [N-1:0]  digit_valid;
    logic          frame_done;
    logic          error_sticky;

    always #5 clk = ~clk;

    seg7_scan_capture #(.NUM_DIGITS(N), .STABLE_CYCLES(S), .CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .anode_n      (anode_n),
        .segment      (segment),
        .err_clr      (err_clr),
        .digits_out   (digits_out),
        .digit_valid  (digit_valid),
        .frame_done   (frame_done),
        .error_sticky (error_sticky)
    );

    logic [6:0] pat [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                             7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

    // Reference state: the current registered sample, how many consecutive
    // edges it has been registered, and whether this run was already captured.
    logic [3:0]   m_val [N];
    logic [N-1:0] m_vld;
    logic         m_fd;
    logic         m_err;
    logic [N-1:0] m_mask;
    logic [N-1:0] reg_a;
    logic [6:0]   reg_s;
    int           run;
    bit           captured;
    int           fd_count;
    int           total = 0;
    int           bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int decode(input logic [6:0] s);
        for (int d = 0; d < 10; d++) begin
            if (pat[d] == s) return d;
        end
        if (s == 7'h7F) return 15;
        return -1;
    endfunction

    function automatic int low_count(input logic [N-1:0] a);
        int c = 0;
        for (int i = 0; i < N; i++) if (a[i] == 1'b0) c++;
        return c;
    endfunction

    function automatic logic [4*N-1:0] m_digits();
        logic [4*N-1:0] v;
        for (int i = 0; i < N; i++) v[4*i +: 4] = m_val[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_val[i] = 4'hF;
        m_vld = '0; m_fd = 0; m_err = 0; m_mask = '0;
        reg_a = '1; reg_s = 7'h7F; run = 1; captured = 0;
    endtask

    task automatic model_edge(input logic [N-1:0] a, input logic [6:0] s, input logic clr);
        bit cap;
        bit inval;
        int p;
        int d;
        cap   = (low_count(reg_a) == 1) && (run >= S) && !captured;
        inval = 0;
        m_fd  = 0;
        if (cap) begin
            p = 0;
            for (int i = 0; i < N; i++) if (reg_a[i] == 1'b0) p = i;
            d = decode(reg_s);
            if (d >= 0 && d <= 9) begin
                m_val[p] = 4'(d); m_vld[p] = 1'b1;
            end else if (d == 15) begin
                m_val[p] = 4'hF; m_vld[p] = 1'b0;
            end else begin
                m_vld[p] = 1'b0; inval = 1;
            end
            m_mask[p] = 1'b1;
            if (m_mask == '1) begin
                m_mask = '0; m_fd = 1;
            end
            captured = 1;
        end
        if (inval) m_err = 1;
        else if (clr) m_err = 0;
        if (a == reg_a && s == reg_s) begin
            if (run < 1000) run++;
        end else begin
            run = 1; captured = 0;
        end
        reg_a = a; reg_s = s;
    endtask

    task automatic step(input logic [N-1:0] a, input logic [6:0] s, input logic clr, input logic r);
        anode_n = a; segment = s; err_clr = clr; rst = r;
        @(posedge clk);
        if (r) model_reset();
        else model_edge(a, s, clr);
        #1;
        check("digits_out", 32'(digits_out), 32'(m_digits()));
        check("digit_valid", 32'(digit_valid), 32'(m_vld));
        check("frame_done", 32'(frame_done), 32'(m_fd));
        check("error_sticky", 32'(error_sticky), 32'(m_err));
        if (frame_done) fd_count++;
    endtask

    task automatic hold(input logic [N-1:0] a, input logic [6:0] s, input int n);
        repeat (n) step(a, s, 1'b0, 1'b0);
    endtask

    task automatic scan(input int base);
        for (int p = 0; p < N; p++) hold(~(N'(1) << p), pat[(base + p) % 10], 8);
    endtask

    initial begin
        model_reset();
        step('1, 7'h7F, 1'b0, 1'b1);
        step('1, 7'h7F, 1'b0, 1'b1);
        check("rst_digits", 32'(digits_out), 32'hFFFF);
        check("rst_valid", 32'(digit_valid), 32'h0);
        check("rst_err", 32'(error_sticky), 32'h0);

        fd_count = 0;
        hold(4'b1110, pat[2], 6);
        check("single_digit", 32'(digits_out[3:0]), 32'h2);
        check("single_valid", 32'(digit_valid), 32'b0001);
        check("single_no_frame", 32'(fd_count), 32'h0);

        fd_count = 0;
        scan(1);
        check("scan_digits", 32'(digits_out), 32'h4321);
        check("scan_valid", 32'(digit_valid), 32'hF);
        check("scan_one_pulse", 32'(fd_count), 32'h1);
        scan(1);
        check("scan_two_pulses", 32'(fd_count), 32'h2);

        hold(4'b1110, pat[7], 3);
        hold(4'b1110, pat[8], 3);
        check("short_hold", 32'(digits_out[3:0]), 32'h1);
        hold(4'b1110, pat[5], 20);
        check("long_hold", 32'(digits_out[3:0]), 32'h5);

        hold(4'b1101, 7'b1111110, 6);
        check("inval_err", 32'(error_sticky), 32'h1);
        check("inval_valid", 32'(digit_valid[1]), 32'h0);
        check("inval_keep", 32'(digits_out[7:4]), 32'h2);
        step(4'b1101, 7'b1111110, 1'b1, 1'b0);
        check("err_clr", 32'(error_sticky), 32'h0);
        hold(4'b1011, 7'b1110111, 4);
        step(4'b1011, 7'b1110111, 1'b1, 1'b0);
        check("err_clr_race", 32'(error_sticky), 32'h1);
        step(4'b1011, 7'b1110111, 1'b1, 1'b0);
        hold(4'b0111, 7'h7F, 6);
        check("blank_val", 32'(digits_out[15:12]), 32'hF);
        check("blank_valid", 32'(digit_valid[3]), 32'h0);
        check("blank_err", 32'(error_sticky), 32'h0);

        hold(4'b1100, pat[3], 10);
        hold(4'b1111, pat[3], 10);

        hold(4'b1110, pat[6], 8);
        hold(4'b1101, pat[7], 8);
        hold(4'b1011, pat[8], 2);
        step(4'b1011, pat[8], 1'b0, 1'b1);
        check("midrst_digits", 32'(digits_out), 32'hFFFF);
        check("midrst_valid", 32'(digit_valid), 32'h0);
        fd_count = 0;
        for (int p = 0; p < N - 1; p++) hold(~(N'(1) << p), pat[p], 8);
        check("midrst_no_early", 32'(fd_count), 32'h0);
        hold(4'b0111, pat[9], 8);
        check("midrst_frame", 32'(fd_count), 32'h1);

        for (int k = 0; k < 400; k++) begin
            logic [N-1:0] a;
            logic [6:0]   s;
            int           r;
            r = $urandom_range(0, 9);
            a = (r == 0) ? N'($urandom) : ~(N'(1) << $urandom_range(0, N - 1));
            r = $urandom_range(0, 9);
            s = (r < 7) ? pat[$urandom_range(0, 9)] : (r == 7) ? 7'h7F : 7'($urandom);
            r = $urandom_range(1, 9);
            for (int c = 0; c < r; c++)
                step(a, s, ($urandom_range(0, 9) == 0), ($urandom_range(0, 199) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
